// File: rtl/bitwise_logic_pkg.sv
// -----------------------------------------------------------------------------
// bitwise_logic_pkg
//
// Shared definitions for the bitwise logic unit: the operation-select width
// and the eight operation codes driven on in_op. Operand/result widths and the
// pipeline depth are parameters of the top level, not package constants.
// -----------------------------------------------------------------------------
package bitwise_logic_pkg;

    // Width of the operation-select field.
    localparam int OP_W = 3;

    // Operation codes. All eight encodings are legal.
    localparam logic [OP_W-1:0] OP_NOT  = 3'b000;  // ~A      (B ignored)
    localparam logic [OP_W-1:0] OP_AND  = 3'b001;  // A & B
    localparam logic [OP_W-1:0] OP_OR   = 3'b010;  // A | B
    localparam logic [OP_W-1:0] OP_XOR  = 3'b011;  // A ^ B
    localparam logic [OP_W-1:0] OP_NOR  = 3'b100;  // ~(A | B)
    localparam logic [OP_W-1:0] OP_NAND = 3'b101;  // ~(A & B)
    localparam logic [OP_W-1:0] OP_XNOR = 3'b110;  // ~(A ^ B)
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;  // A       (B ignored)

    // Number of result flags carried alongside the result when the flag
    // outputs are built in (zero, parity).
    localparam int FLAG_W = 2;

endpackage : bitwise_logic_pkg

// File: rtl/logic_pipe_stage.sv
// -----------------------------------------------------------------------------
// logic_pipe_stage
//
// One elastic pipeline stage: a 2-entry skid buffer (main register plus skid
// register) with valid/ready handshakes on both sides.
//
// Key property: ready_o is a flop whose value is "skid entry empty" for the
// state being loaded. It never depends combinationally on ready_i, so stages
// can be chained without building a long ready path.
//
// Behaviour:
//   - Main register drives the downstream side (valid_o/data_o).
//   - An accepted beat goes straight into main when main is empty or is
//     being emptied in the same cycle; only otherwise does it land in skid.
//   - When main drains and skid is full, skid moves into main.
//   - ready_o is 0 during reset and on the first edge after release.
//
// Parameters:
//   DATA_W   payload width in bits
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   valid_i  in   upstream beat offered
//   ready_o  out  stage accepts a beat this cycle (registered)
//   data_i   in   upstream payload
//   valid_o  out  beat offered downstream
//   ready_i  in   downstream accepts
//   data_o   out  downstream payload (held stable while stalled)
// -----------------------------------------------------------------------------
module logic_pipe_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              ready_q,      ready_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = valid_i & ready_q;
    assign out_fire = main_valid_q & ready_i;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so that no
        // path through the branches below leaves it unassigned (no latches).
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (skid_valid_q) begin
            // Skid full implies ready_q is low, so nothing arrives this cycle;
            // the only possible move is skid -> main when main drains.
            if (out_fire) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!main_valid_q || out_fire) begin
                // Main is free (or freeing): bypass the skid entry so a
                // simultaneous accept/emit leaves occupancy unchanged.
                main_valid_d = 1'b1;
                main_data_d  = data_i;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = data_i;
            end
        end else if (out_fire) begin
            main_valid_d = 1'b0;
        end

        // Registered ready: advertise space for the next cycle based on the
        // skid state being loaded now.
        ready_d = ~skid_valid_d;
    end

    // NOTE: state is updated with non-blocking assignments so every flop in
    // the design samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload registers are reset as well as the valids, so
            // out_result reads zero after reset rather than stale data.
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = main_valid_q;
    assign data_o  = main_data_q;

endmodule : logic_pipe_stage

// File: rtl/bitwise_logic_unit.sv
// -----------------------------------------------------------------------------
// bitwise_logic_unit
//
// Pipelined WIDTH-bit bitwise logic unit. The result of in_op applied to
// in_a/in_b is computed combinationally and captured into the first of
// STAGES elastic stages (logic_pipe_stage) on input transfer; the remaining
// stages carry it unchanged. One beat per cycle is sustained while the
// consumer keeps out_ready high; under backpressure the chain absorbs up to
// 2*STAGES beats. Beats leave in acceptance order.
//
// Optional feature (macro BITWISE_LOGIC_UNIT_FLAGS_EN):
//   When defined, adds out_zero (result == 0) and out_parity (XOR-reduce of
//   the result). Both are computed ahead of stage 1 and travel with the
//   result through the pipeline. When undefined, the ports and the flag
//   bits in the stage payload are absent.
//
// Parameters:
//   WIDTH    operand/result width in bits (1..64)
//   STAGES   number of elastic pipeline stages (1..4)
//
// Ports:
//   Clk         in   rising-edge clock
//   Reset_n     in   asynchronous active-low reset
//   in_valid    in   operand beat offered
//   in_ready    out  unit accepts a beat this cycle
//   in_op       in   operation select (see bitwise_logic_pkg)
//   in_a        in   operand A
//   in_b        in   operand B (ignored by NOT A and PASS A)
//   out_valid   out  result beat offered
//   out_ready   in   consumer accepts the result
//   out_result  out  result
//   out_zero    out  result is zero            (flags build only)
//   out_parity  out  XOR-reduce of the result  (flags build only)
// -----------------------------------------------------------------------------
module bitwise_logic_unit
    import bitwise_logic_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_parity
`endif
);

`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
    localparam int PAYLOAD_W = WIDTH + FLAG_W;
`else
    localparam int PAYLOAD_W = WIDTH;
`endif

    // -------------------------------------------------------------------------
    // Operation decode
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] op_result;

    always_comb begin
        op_result = in_a;
        case (in_op)
            OP_NOT:  op_result = ~in_a;
            OP_AND:  op_result = in_a & in_b;
            OP_OR:   op_result = in_a | in_b;
            OP_XOR:  op_result = in_a ^ in_b;
            OP_NOR:  op_result = ~(in_a | in_b);
            OP_NAND: op_result = ~(in_a & in_b);
            OP_XNOR: op_result = ~(in_a ^ in_b);
            OP_PASS: op_result = in_a;
            default: op_result = in_a;
        endcase
    end

    // Stage-1 payload: result in the low bits, flags (when built) above it.
    logic [PAYLOAD_W-1:0] in_payload;

`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
    assign in_payload = {^op_result, ~|op_result, op_result};
`else
    assign in_payload = op_result;
`endif

    // -------------------------------------------------------------------------
    // Stage chain. Index i is the boundary in front of stage i; index STAGES
    // is the unit output.
    // -------------------------------------------------------------------------
    logic [STAGES:0]      chain_valid;
    logic [STAGES:0]      chain_ready;
    logic [PAYLOAD_W-1:0] chain_data [0:STAGES];

    assign chain_valid[0]      = in_valid;
    assign chain_data[0]       = in_payload;
    assign in_ready            = chain_ready[0];
    assign chain_ready[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic_pipe_stage #(
            .DATA_W (PAYLOAD_W)
        ) u_stage (
            .clk     (Clk),
            .rst_n   (Reset_n),
            .valid_i (chain_valid[i]),
            .ready_o (chain_ready[i]),
            .data_i  (chain_data[i]),
            .valid_o (chain_valid[i+1]),
            .ready_i (chain_ready[i+1]),
            .data_o  (chain_data[i+1])
        );
    end

    assign out_valid  = chain_valid[STAGES];
    assign out_result = chain_data[STAGES][WIDTH-1:0];

`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
    assign out_zero   = chain_data[STAGES][WIDTH];
    assign out_parity = chain_data[STAGES][WIDTH+1];
`endif

endmodule : bitwise_logic_unit

// File: tb/tb_bitwise_logic_unit.sv
// -----------------------------------------------------------------------------
// tb_bitwise_logic_unit
//
// Directed bench for bitwise_logic_unit at WIDTH=8, STAGES=2: reset state,
// all eight ops back to back, backpressure fill/drain, random stalls against
// a reference queue, asynchronous reset mid-flight, and (with
// BITWISE_LOGIC_UNIT_FLAGS_EN) the zero/parity flags.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at that point or on the falling edge.
// -----------------------------------------------------------------------------
module tb_bitwise_logic_unit;
    import bitwise_logic_pkg::*;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             Clk      = 1'b0;
    logic             Reset_n  = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [OP_W-1:0]  in_op    = OP_PASS;
    logic [WIDTH-1:0] in_a     = '0;
    logic [WIDTH-1:0] in_b     = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
    logic             out_zero;
    logic             out_parity;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    bitwise_logic_unit #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
        ,
        .out_zero   (out_zero),
        .out_parity (out_parity)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model for the random section.
    function automatic logic [WIDTH-1:0] model(input logic [OP_W-1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            3'b000:  return ~a;
            3'b001:  return a & b;
            3'b010:  return a | b;
            3'b011:  return a ^ b;
            3'b100:  return ~(a | b);
            3'b101:  return ~(a & b);
            3'b110:  return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // Scoreboard: on the falling edge, look at the handshakes that will
    // complete on the next rising edge.
    logic [WIDTH-1:0] exp_q[$];
    logic             sb_en      = 1'b0;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_res   = '0;
    int               acc_cnt    = 0;
    int               out_cnt    = 0;

    always @(negedge Clk) begin
        if (sb_en) begin
            if (prev_stall) begin
                check("stall_hold_valid", 64'(out_valid), 64'd1);
                check("stall_hold_data", 64'(out_result), 64'(prev_res));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat_queue_size", 64'(exp_q.size()), 64'd1);
                end else begin
                    check("random_beat", 64'(out_result), 64'(exp_q.pop_front()));
                    out_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_op, in_a, in_b));
                acc_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_result;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [WIDTH-1:0] ops_exp [0:7];
    logic [WIDTH-1:0] got_q[$];
    int               accepted;
    int               idx;
    logic             acc_now;
    logic             out_now;
    logic [WIDTH-1:0] out_val;
    int               seen_valid;

    initial begin
        ops_exp[0] = 8'h5A; ops_exp[1] = 8'h24; ops_exp[2] = 8'hBD; ops_exp[3] = 8'h99;
        ops_exp[4] = 8'h42; ops_exp[5] = 8'hDB; ops_exp[6] = 8'h66; ops_exp[7] = 8'hA5;

        // ---------------- Reset: held 3 cycles with in_valid high ----------
        Reset_n  = 1'b0;
        in_valid = 1'b1;
        in_op    = OP_PASS;
        in_a     = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk); #1;
            check("reset_in_ready", 64'(in_ready), 64'd0);
        end
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_result", 64'(out_result), 64'h0);
        Reset_n  = 1'b1;
        in_valid = 1'b0;
        check("release_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge Clk); #1;
        check("release_in_ready_high", 64'(in_ready), 64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);

        // ---------------- All ops back to back, a=A5 b=3C ------------------
        out_ready = 1'b1;
        in_a      = 8'hA5;
        in_b      = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_op    = 3'(i);
            check("ops_in_ready", 64'(in_ready), 64'd1);
            @(posedge Clk); #1;
            if (i == 0) begin
                check("ops_first_latency_out_valid", 64'(out_valid), 64'd0);
            end else begin
                check("ops_out_valid", 64'(out_valid), 64'd1);
                check("ops_result", 64'(out_result), 64'(ops_exp[i-1]));
            end
        end
        in_valid = 1'b0;
        @(posedge Clk); #1;
        check("ops_last_out_valid", 64'(out_valid), 64'd1);
        check("ops_last_result", 64'(out_result), 64'(ops_exp[7]));
        @(posedge Clk); #1;
        check("ops_empty_out_valid", 64'(out_valid), 64'd0);

        // ---------------- Backpressure: stream 1..6 with out_ready low ------
        out_ready = 1'b0;
        in_op     = OP_PASS;
        in_b      = 8'h00;
        accepted  = 0;
        idx       = 1;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_a     = 8'(idx);
            acc_now  = in_ready;
            @(posedge Clk); #1;
            if (acc_now) begin
                accepted++;
                idx++;
            end
        end
        check("bp_accepted", 64'(accepted), 64'd4);
        check("bp_in_ready_full", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_out_result_head", 64'(out_result), 64'h01);
        @(posedge Clk); #1;
        check("bp_out_result_stable", 64'(out_result), 64'h01);

        out_ready = 1'b1;
        got_q.delete();
        for (int c = 0; c < 20; c++) begin
            in_valid = (idx <= 6);
            in_a     = 8'(idx);
            acc_now  = in_valid && in_ready;
            out_now  = out_valid;
            out_val  = out_result;
            @(posedge Clk); #1;
            if (acc_now) idx++;
            if (out_now) got_q.push_back(out_val);
        end
        in_valid = 1'b0;
        check("bp_drain_count", 64'(got_q.size()), 64'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < got_q.size()) check("bp_drain_order", 64'(got_q[k]), 64'(k + 1));
        end

        // ---------------- Random stalls against the reference queue --------
        exp_q.delete();
        acc_cnt = 0;
        out_cnt = 0;
        sb_en   = 1'b1;
        for (int c = 0; c < 20000 && acc_cnt < 1000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_op     = 3'($urandom);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge Clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            @(posedge Clk); #1;
        end
        check("random_accepted", 64'(acc_cnt), 64'd1000);
        check("random_emitted", 64'(out_cnt), 64'd1000);
        check("random_queue_empty", 64'(exp_q.size()), 64'd0);
        sb_en = 1'b0;

        // ---------------- Reset mid-flight ---------------------------------
        @(posedge Clk); #1;
        out_ready = 1'b0;
        in_op     = OP_PASS;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_a     = 8'(8'h11 * (k + 1));
            check("midrst_fill_ready", 64'(in_ready), 64'd1);
            @(posedge Clk); #1;
        end
        in_valid = 1'b0;
        check("midrst_inflight_valid", 64'(out_valid), 64'd1);
        Reset_n = 1'b0;
        #2;
        check("midrst_out_valid_now", 64'(out_valid), 64'd0);
        check("midrst_out_result_now", 64'(out_result), 64'h0);
        check("midrst_in_ready_now", 64'(in_ready), 64'd0);
        #3;
        Reset_n   = 1'b1;
        out_ready = 1'b1;
        seen_valid = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge Clk); #1;
            if (out_valid) seen_valid++;
        end
        check("midrst_no_stale_beats", 64'(seen_valid), 64'd0);
        check("midrst_in_ready_back", 64'(in_ready), 64'd1);

`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
        // ---------------- Flags ---------------------------------------------
        in_valid = 1'b1;
        in_op    = OP_XOR;
        in_a     = 8'h0F;
        in_b     = 8'h0F;
        @(posedge Clk); #1;
        in_op = OP_OR;
        in_a  = 8'h07;
        in_b  = 8'h00;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        check("flags_xor_valid", 64'(out_valid), 64'd1);
        check("flags_xor_result", 64'(out_result), 64'h00);
        check("flags_xor_zero", 64'(out_zero), 64'd1);
        check("flags_xor_parity", 64'(out_parity), 64'd0);
        @(posedge Clk); #1;
        check("flags_or_valid", 64'(out_valid), 64'd1);
        check("flags_or_result", 64'(out_result), 64'h07);
        check("flags_or_zero", 64'(out_zero), 64'd0);
        check("flags_or_parity", 64'(out_parity), 64'd1);
        @(posedge Clk); #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_bitwise_logic_unit
